// File: rtl/receiver_module_pkg.sv
// Shared types for the UART receive path: bit-FSM state encoding and AES block width.
// No logic; imported by the UART receiver and the block assembler.
package receiver_module_pkg;

    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/receiver_module_uart_receiver.sv
// 8N1 UART receiver: 2-flop synchroniser plus mid-bit sampling FSM; byte_done/frame_error pulse
// on the stop-bit sample. Never stalls: the line cannot be backpressured.
module UART_receiver
    import receiver_module_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_done_o,
    output logic       frame_error_o,
    output logic       idle_o
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_meta_q, rxs_q;
    logic             bit_tick;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= UART_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    assign bit_tick = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        unique case (state_q)
            UART_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = UART_START;
            end
            UART_START: begin
                // Half a bit in: a line that is high again was only a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rxs_q ? UART_IDLE : UART_DATA;
                end
            end
            UART_DATA: begin
                if (bit_tick) begin
                    cnt_d     = '0;
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = UART_STOP;
                end
            end
            UART_STOP: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    state_d = UART_IDLE;
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    always_comb begin
        byte_done_o   = (state_q == UART_STOP) && bit_tick &&  rxs_q;
        frame_error_o = (state_q == UART_STOP) && bit_tick && !rxs_q;
        idle_o        = (state_q == UART_IDLE);
    end

    assign rx_byte_o = shift_q;

endmodule

// File: rtl/receiver_module.sv
// UART-to-AES block assembler: packs BYTES_PER_BLK bytes into a held block; valid rises 1 clk after
// the last byte_done. A held block never stalls the UART; a block finishing while held is dropped (overflow).
module receiver_module
    import receiver_module_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 434,
    parameter int BYTES_PER_BLK = BLOCK_W / 8,
    parameter int IDLE_TIMEOUT  = 65535
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx,
    output logic [8*BYTES_PER_BLK-1:0] block_UART_rx_to_aes,
    output logic                       block_valid,
    input  logic                       read_en,
    output logic                       overflow,
    output logic                       frame_error
);

    localparam int               BLK_W   = 8 * BYTES_PER_BLK;
    localparam int               BCW     = (BYTES_PER_BLK > 1) ? $clog2(BYTES_PER_BLK) : 1;
    localparam int               IDW     = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [BCW-1:0]   BC_LAST = BCW'(BYTES_PER_BLK - 1);
    localparam logic [IDW-1:0]   ID_LAST = IDW'(IDLE_TIMEOUT);

    logic [7:0]       rx_byte;
    logic             byte_done;
    logic             uart_idle;

    logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [BLK_W-1:0] shadow_q, shadow_d;
    logic [BLK_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic [IDW-1:0]   idle_cnt_q, idle_cnt_d;

    UART_receiver #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk_i         (clk),
        .reset_i       (reset),
        .rx_i          (rx),
        .rx_byte_o     (rx_byte),
        .byte_done_o   (byte_done),
        .frame_error_o (frame_error),
        .idle_o        (uart_idle)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q <= '0;
            shadow_q   <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shadow_q   <= shadow_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shadow_d   = shadow_q;
        data_d     = data_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        idle_cnt_d = idle_cnt_q;

        if (valid_q && read_en) valid_d = 1'b0;

        if (byte_done) begin
            idle_cnt_d = '0;
            for (int k = 0; k < BYTES_PER_BLK; k++) begin
                if (byte_cnt_q == BCW'(k)) shadow_d[BLK_W-1-8*k -: 8] = rx_byte;
            end
            if (byte_cnt_q == BC_LAST) begin
                byte_cnt_d = '0;
                // An ack landing on the completion cycle frees the output for the new block.
                if (!valid_q || read_en) begin
                    data_d  = shadow_d;
                    valid_d = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
            end
        end else if (uart_idle) begin
            if (idle_cnt_q == ID_LAST) begin
                if (byte_cnt_q != '0) byte_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
    end

    assign block_UART_rx_to_aes = data_q;
    assign block_valid          = valid_q;
    assign overflow             = overflow_q;

endmodule

// File: tb/tb_receiver_module.sv
// Directed bench for receiver_module with CLKS_PER_BIT=8, IDLE_TIMEOUT=200.
module tb_receiver_module;

    localparam int CPB = 8;
    localparam int TMO = 200;
    localparam int FRM = 10 * CPB;

    logic         clk = 1'b0;
    logic         reset;
    logic         rx;
    logic         read_en;
    logic [127:0] blk;
    logic         block_valid;
    logic         overflow;
    logic         frame_error;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    receiver_module #(
        .CLKS_PER_BIT  (CPB),
        .BYTES_PER_BLK (16),
        .IDLE_TIMEOUT  (TMO)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .rx                   (rx),
        .block_UART_rx_to_aes (blk),
        .block_valid          (block_valid),
        .read_en              (read_en),
        .overflow             (overflow),
        .frame_error          (frame_error)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        tick(n);
    endtask

    // mode 0: plain; 1: check valid rises exactly 1 clk after the stop sample;
    // 2: ack on the completion cycle; 3: expect a frame_error pulse
    task automatic send_byte(input logic [7:0] b, input logic stop, input int mode,
                             input logic [127:0] exp_blk);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int c = 0; c < FRM; c++) begin
            @(posedge clk);
            #1;
            rx = frame[c/CPB];
            if (c == FRM - 2) begin
                if (mode == 1) chk("valid_before_done", 128'(block_valid), 128'd0);
                if (mode == 2) read_en = 1'b1;
                if (mode == 3) chk("frame_error_pulse", 128'(frame_error), 128'd1);
            end else if (c == FRM - 1) begin
                if (mode == 1 || mode == 2) begin
                    read_en = 1'b0;
                    chk("valid_rise", 128'(block_valid), 128'd1);
                    chk("block_data", blk, exp_blk);
                end
                if (mode == 2) chk("no_overflow_on_ack", 128'(overflow), 128'd0);
                if (mode == 3) chk("frame_error_1clk", 128'(frame_error), 128'd0);
            end
        end
    endtask

    task automatic send_bytes(input logic [127:0] b, input int first, input int last,
                              input int mode_last, input logic [127:0] exp_blk);
        for (int i = first; i <= last; i++)
            send_byte(b[127-8*i -: 8], 1'b1, (i == last) ? mode_last : 0, exp_blk);
    endtask

    task automatic ack(input string tag);
        read_en = 1'b1;
        tick(1);
        read_en = 1'b0;
        chk(tag, 128'(block_valid), 128'd0);
    endtask

    localparam logic [127:0] B1  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] BA5 = {16{8'hA5}};
    localparam logic [127:0] B3C = {16{8'h3C}};
    localparam logic [127:0] B6  = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    localparam logic [127:0] B3  = 128'h112233445566778899AABBCCDDEEFF00;
    localparam logic [127:0] B4  = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] BEE = {16{8'hEE}};
    localparam logic [127:0] B5  = 128'h101112131415161718191A1B1C1D1E1F;
    localparam logic [127:0] B7A = {16{8'h5A}};
    localparam logic [127:0] B7B = 128'hC0FFEE00DEADBEEF0123456789ABCDEF;

    initial begin
        bit fe_seen;
        reset   = 1'b1;
        rx      = 1'b1;
        read_en = 1'b0;
        tick(4);
        chk("rst_valid",    128'(block_valid), 128'd0);
        chk("rst_overflow", 128'(overflow),    128'd0);
        chk("rst_data",     blk,               128'd0);
        chk("rst_frame_err",128'(frame_error), 128'd0);
        reset = 1'b0;
        tick(20);

        // back-to-back ramp block, then ack
        send_bytes(B1, 0, 15, 1, B1);
        ack("t1_ack");

        // held block, second block dropped
        tick(10);
        send_bytes(BA5, 0, 15, 1, BA5);
        chk("t2_no_ovf_yet", 128'(overflow), 128'd0);
        send_bytes(B3C, 0, 15, 0, B3C);
        tick(2);
        chk("t2_overflow", 128'(overflow),    128'd1);
        chk("t2_valid",    128'(block_valid), 128'd1);
        chk("t2_data_held", blk, BA5);

        // reset mid-block, mid-byte
        send_bytes(B6, 0, 6, 0, B6);
        rx = 1'b0;
        tick(12);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rx    = 1'b1;
        chk("t6_valid",    128'(block_valid), 128'd0);
        chk("t6_overflow", 128'(overflow),    128'd0);
        chk("t6_data",     blk,               128'd0);
        idle(16);
        send_bytes(B6, 0, 15, 1, B6);
        ack("t6_ack");

        // bad stop bit in the middle of a block
        send_bytes(B3, 0, 2, 0, B3);
        send_byte(8'h55, 1'b0, 3, B3);
        idle(16);
        send_bytes(B3, 3, 15, 1, B3);
        ack("t3_ack");

        // 2-clk glitch on the line
        idle(5);
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        fe_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (frame_error) fe_seen = 1'b1;
        end
        chk("t4_no_frame_err", 128'(fe_seen), 128'd0);
        idle(10);
        send_bytes(B4, 0, 15, 1, B4);
        ack("t4_ack");

        // stale partial block dropped after idle timeout
        send_bytes(BEE, 0, 4, 0, BEE);
        idle(250);
        send_bytes(B5, 0, 15, 1, B5);
        ack("t5_ack");

        // ack coinciding with completion of the next block
        send_bytes(B7A, 0, 15, 1, B7A);
        send_bytes(B7B, 0, 15, 2, B7B);
        ack("t7_ack");
        chk("t7_overflow", 128'(overflow), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
